mips_pipe_ctrl: RTL and testbench

Parametrised fetch and hazard controller for the 5-stage pipelined MIPS core; it supersedes the single-cycle PC register and branch mux. It owns the PC, the IF/ID register, and a shadow copy of the ID/EX, EX/MEM and MEM/WB hazard fields. From these it generates stall, flush and ALU-operand forwarding selects. The datapath keeps its own data pipeline registers and applies `stall`/`flush` exactly as specified here.

---
 rtl/mips_pipe_ctrl_if.sv | 36 +++
 rtl/mips_pipe_ctrl.sv | 149 ++++++++++++++
 tb/tb_mips_pipe_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pipe_ctrl_if.sv
// Datapath-facing signal bundle of the MIPS fetch/hazard controller.
// The controller connects through the master modport, the datapath through the slave modport.
interface mips_pipe_ctrl_if #(
    parameter int AW = 32
) ();
    logic [31:0]   instr_in;
    logic          id_regwrite;
    logic          id_memread;
    logic          id_uses_rs;
    logic          id_uses_rt;
    logic [4:0]    id_wreg;
    logic          ex_branch_taken;
    logic [AW-1:0] ex_target;

    logic [AW-1:0] pc;
    logic [31:0]   ifid_instr;
    logic [AW-1:0] ifid_pc4;
    logic          ifid_valid;
    logic          idex_valid;
    logic          stall;
    logic          flush;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;

    modport master (
        input  instr_in, id_regwrite, id_memread, id_uses_rs, id_uses_rt, id_wreg,
               ex_branch_taken, ex_target,
        output pc, ifid_instr, ifid_pc4, ifid_valid, idex_valid, stall, flush, fwd_a, fwd_b
    );

    modport slave (
        output instr_in, id_regwrite, id_memread, id_uses_rs, id_uses_rt, id_wreg,
               ex_branch_taken, ex_target,
        input  pc, ifid_instr, ifid_pc4, ifid_valid, idex_valid, stall, flush, fwd_a, fwd_b
    );
endinterface

// File: rtl/mips_pipe_ctrl.sv
// Fetch and hazard controller for the 5-stage MIPS pipeline: owns PC and IF/ID, tracks
// hazard fields of later stages, and produces stall, flush and operand forwarding selects.
module mips_pipe_ctrl #(
    parameter int            AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter bit            FWD_EN   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    mips_pipe_ctrl_if.master bus
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_plus4;
    logic [AW-1:0] ifid_pc4_q;
    logic [31:0]   ifid_instr_q;
    logic          ifid_valid_q;
    logic [4:0]    ifid_rs;
    logic [4:0]    ifid_rt;

    logic [4:0]    idex_rs;
    logic [4:0]    idex_rt;
    logic [4:0]    idex_wreg;
    logic          idex_regwrite;
    logic          idex_memread;
    logic          idex_valid_q;
    logic [4:0]    exmem_wreg;
    logic          exmem_regwrite;
    logic [4:0]    memwb_wreg;
    logic          memwb_regwrite;

    logic          taken;
    logic          load_use;
    logic          raw_hazard;
    logic          hazard;
    logic          stall;

    // A source only conflicts with a real (non-$0) destination.
    function automatic logic id_hit(input logic uses_rs, input logic [4:0] rs,
                                    input logic uses_rt, input logic [4:0] rt,
                                    input logic [4:0] wreg);
        return (wreg != 5'd0) && ((uses_rs && (rs == wreg)) || (uses_rt && (rt == wreg)));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic exmem_rw, input logic [4:0] exmem_w,
                                           input logic memwb_rw, input logic [4:0] memwb_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (exmem_rw && (exmem_w != 5'd0) && (exmem_w == src)) begin
            sel = 2'b10;
        end else if (memwb_rw && (memwb_w != 5'd0) && (memwb_w == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign ifid_rs  = ifid_instr_q[25:21];
    assign ifid_rt  = ifid_instr_q[20:16];
    assign pc_plus4 = pc_q + AW'(4);
    assign taken    = bus.ex_branch_taken;

    // Without forwarding every in-flight writer of a source register blocks issue,
    // including WB, so distances 1/2/3 cost 3/2/1 stall cycles.
    always_comb begin
        load_use   = idex_memread &&
                     id_hit(bus.id_uses_rs, ifid_rs, bus.id_uses_rt, ifid_rt, idex_wreg);
        raw_hazard = 1'b0;
        if (!FWD_EN) begin
            raw_hazard =
                (idex_regwrite  && id_hit(bus.id_uses_rs, ifid_rs, bus.id_uses_rt, ifid_rt, idex_wreg))  ||
                (exmem_regwrite && id_hit(bus.id_uses_rs, ifid_rs, bus.id_uses_rt, ifid_rt, exmem_wreg)) ||
                (memwb_regwrite && id_hit(bus.id_uses_rs, ifid_rs, bus.id_uses_rt, ifid_rt, memwb_wreg));
        end
        hazard = ifid_valid_q && (load_use || raw_hazard);
        stall  = hazard && !taken;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else if (taken) begin
            pc_q         <= bus.ex_target;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else if (!stall) begin
            pc_q         <= pc_plus4;
            ifid_instr_q <= bus.instr_in;
            ifid_pc4_q   <= pc_plus4;
            ifid_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_rs       <= '0;
            idex_rt       <= '0;
            idex_wreg     <= '0;
            idex_regwrite <= 1'b0;
            idex_memread  <= 1'b0;
            idex_valid_q  <= 1'b0;
        end else if (taken || stall) begin
            idex_rs       <= '0;
            idex_rt       <= '0;
            idex_wreg     <= '0;
            idex_regwrite <= 1'b0;
            idex_memread  <= 1'b0;
            idex_valid_q  <= 1'b0;
        end else begin
            idex_rs       <= ifid_rs;
            idex_rt       <= ifid_rt;
            idex_wreg     <= bus.id_wreg;
            idex_regwrite <= bus.id_regwrite && ifid_valid_q;
            idex_memread  <= bus.id_memread && ifid_valid_q;
            idex_valid_q  <= ifid_valid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_wreg     <= '0;
            exmem_regwrite <= 1'b0;
            memwb_wreg     <= '0;
            memwb_regwrite <= 1'b0;
        end else begin
            exmem_wreg     <= idex_wreg;
            exmem_regwrite <= idex_regwrite;
            memwb_wreg     <= exmem_wreg;
            memwb_regwrite <= exmem_regwrite;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.ifid_instr = ifid_instr_q;
    assign bus.ifid_pc4   = ifid_pc4_q;
    assign bus.ifid_valid = ifid_valid_q;
    assign bus.idex_valid = idex_valid_q;
    assign bus.stall      = stall;
    assign bus.flush      = taken;
    assign bus.fwd_a      = FWD_EN ? fwd_sel(idex_rs, exmem_regwrite, exmem_wreg,
                                             memwb_regwrite, memwb_wreg) : 2'b00;
    assign bus.fwd_b      = FWD_EN ? fwd_sel(idex_rt, exmem_regwrite, exmem_wreg,
                                             memwb_regwrite, memwb_wreg) : 2'b00;

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Directed bench for mips_pipe_ctrl: a forwarding instance driven by a cycle table and a
// non-forwarding instance checked for RAW stall lengths; instruction memory and decode are modelled here.
module tb_mips_pipe_ctrl;

    typedef struct packed {
        logic       rw;
        logic       mr;
        logic       urs;
        logic       urt;
        logic [4:0] wreg;
    } dec_t;

    typedef struct {
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        ifv;
        logic        idv;
        logic        st;
        logic        fl;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [31:0] imem_a [64];
    logic [31:0] imem_b [64];
    vec_t        vecs   [22];
    dec_t        dec_a;
    dec_t        dec_b;

    mips_pipe_ctrl_if #(.AW(32)) bus_a ();
    mips_pipe_ctrl_if #(.AW(32)) bus_b ();

    mips_pipe_ctrl #(.AW(32), .RESET_PC(32'h100), .FWD_EN(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    mips_pipe_ctrl #(.AW(32), .RESET_PC(32'h0), .FWD_EN(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'h20};
    endfunction

    function automatic logic [31:0] lw_ins(input int rt, input int base);
        return {6'h23, 5'(base), 5'(rt), 16'h0000};
    endfunction

    function automatic logic [31:0] beq_ins(input int rs, input int rt);
        return {6'h04, 5'(rs), 5'(rt), 16'h0010};
    endfunction

    // Reference decode of the IF/ID instruction; an all-zero word is a nop.
    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        d = '0;
        if (ins != 32'd0) begin
            case (ins[31:26])
                6'h00: begin d.rw = 1'b1; d.urs = 1'b1; d.urt = 1'b1; d.wreg = ins[15:11]; end
                6'h23: begin d.rw = 1'b1; d.mr = 1'b1; d.urs = 1'b1; d.wreg = ins[20:16]; end
                6'h04: begin d.urs = 1'b1; d.urt = 1'b1; end
                default: d = '0;
            endcase
        end
        return d;
    endfunction

    function automatic vec_t mk(input logic br, input logic [31:0] tgt, input logic [31:0] pc,
                                input logic [31:0] pc4, input logic ifv, input logic idv,
                                input logic st, input logic fl, input logic [1:0] fa,
                                input logic [1:0] fb);
        vec_t v;
        v.br = br; v.tgt = tgt; v.pc = pc; v.pc4 = pc4; v.ifv = ifv; v.idv = idv;
        v.st = st; v.fl = fl; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    assign bus_a.instr_in    = imem_a[bus_a.pc[7:2]];
    assign dec_a             = decode(bus_a.ifid_instr);
    assign bus_a.id_regwrite = dec_a.rw;
    assign bus_a.id_memread  = dec_a.mr;
    assign bus_a.id_uses_rs  = dec_a.urs;
    assign bus_a.id_uses_rt  = dec_a.urt;
    assign bus_a.id_wreg     = dec_a.wreg;

    assign bus_b.instr_in    = imem_b[bus_b.pc[7:2]];
    assign dec_b             = decode(bus_b.ifid_instr);
    assign bus_b.id_regwrite = dec_b.rw;
    assign bus_b.id_memread  = dec_b.mr;
    assign bus_b.id_uses_rs  = dec_b.urs;
    assign bus_b.id_uses_rt  = dec_b.urt;
    assign bus_b.id_wreg     = dec_b.wreg;

    task automatic applyStimulus(input vec_t v);
        bus_a.ex_branch_taken = v.br;
        bus_a.ex_target       = v.tgt;
    endtask

    task automatic checkOutput(input string name, input int row,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL row %0d %s: actual %h required %h", row, name, act, exp);
        end
    endtask

    task automatic checkRow(input int r, input vec_t v);
        checkOutput("pc",         r, bus_a.pc,         v.pc);
        checkOutput("ifid_pc4",   r, bus_a.ifid_pc4,   v.pc4);
        checkOutput("ifid_valid", r, 32'(bus_a.ifid_valid), 32'(v.ifv));
        checkOutput("idex_valid", r, 32'(bus_a.idex_valid), 32'(v.idv));
        checkOutput("stall",      r, 32'(bus_a.stall), 32'(v.st));
        checkOutput("flush",      r, 32'(bus_a.flush), 32'(v.fl));
        checkOutput("fwd_a",      r, 32'(bus_a.fwd_a), 32'(v.fa));
        checkOutput("fwd_b",      r, 32'(bus_a.fwd_b), 32'(v.fb));
    endtask

    initial begin
        logic [31:0] pc_b_exp [11];
        logic [10:0] stall_b_exp;

        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_a.ex_branch_taken = 1'b0;
        bus_a.ex_target       = '0;
        bus_b.ex_branch_taken = 1'b0;
        bus_b.ex_target       = '0;

        for (int i = 0; i < 64; i++) begin
            imem_a[i] = 32'd0;
            imem_b[i] = 32'd0;
        end
        imem_a[0]  = r_ins(3, 1, 2);
        imem_a[1]  = r_ins(4, 3, 5);
        imem_a[2]  = r_ins(7, 1, 2);
        imem_a[4]  = r_ins(8, 7, 9);
        imem_a[5]  = r_ins(0, 1, 2);
        imem_a[6]  = r_ins(9, 0, 5);
        imem_a[7]  = r_ins(3, 1, 2);
        imem_a[8]  = r_ins(3, 1, 2);
        imem_a[9]  = r_ins(6, 3, 3);
        imem_a[10] = lw_ins(2, 1);
        imem_a[11] = r_ins(4, 2, 2);
        imem_a[12] = beq_ins(1, 1);
        imem_a[16] = lw_ins(10, 1);
        imem_a[17] = r_ins(11, 10, 10);

        imem_b[0]  = r_ins(3, 1, 2);
        imem_b[1]  = r_ins(4, 3, 5);
        imem_b[4]  = r_ins(6, 4, 7);

        //            br tgt           pc            pc4           ifv idv st fl fa    fb
        vecs[0]  = mk(0, 32'h0,        32'h100,      32'h0,        0, 0, 0, 0, 2'b00, 2'b00);
        vecs[1]  = mk(0, 32'h0,        32'h104,      32'h104,      1, 0, 0, 0, 2'b00, 2'b00);
        vecs[2]  = mk(0, 32'h0,        32'h108,      32'h108,      1, 1, 0, 0, 2'b00, 2'b00);
        vecs[3]  = mk(0, 32'h0,        32'h10C,      32'h10C,      1, 1, 0, 0, 2'b10, 2'b00);
        vecs[4]  = mk(0, 32'h0,        32'h110,      32'h110,      1, 1, 0, 0, 2'b00, 2'b00);
        vecs[5]  = mk(0, 32'h0,        32'h114,      32'h114,      1, 1, 0, 0, 2'b00, 2'b00);
        vecs[6]  = mk(0, 32'h0,        32'h118,      32'h118,      1, 1, 0, 0, 2'b01, 2'b00);
        vecs[7]  = mk(0, 32'h0,        32'h11C,      32'h11C,      1, 1, 0, 0, 2'b00, 2'b00);
        vecs[8]  = mk(0, 32'h0,        32'h120,      32'h120,      1, 1, 0, 0, 2'b00, 2'b00);
        vecs[9]  = mk(0, 32'h0,        32'h124,      32'h124,      1, 1, 0, 0, 2'b00, 2'b00);
        vecs[10] = mk(0, 32'h0,        32'h128,      32'h128,      1, 1, 0, 0, 2'b00, 2'b00);
        vecs[11] = mk(0, 32'h0,        32'h12C,      32'h12C,      1, 1, 0, 0, 2'b10, 2'b10);
        vecs[12] = mk(0, 32'h0,        32'h130,      32'h130,      1, 1, 1, 0, 2'b00, 2'b00);
        vecs[13] = mk(0, 32'h0,        32'h130,      32'h130,      1, 0, 0, 0, 2'b00, 2'b00);
        vecs[14] = mk(0, 32'h0,        32'h134,      32'h134,      1, 1, 0, 0, 2'b01, 2'b01);
        vecs[15] = mk(1, 32'h40,       32'h138,      32'h138,      1, 1, 0, 1, 2'b00, 2'b00);
        vecs[16] = mk(0, 32'h0,        32'h40,       32'h0,        0, 0, 0, 0, 2'b00, 2'b00);
        vecs[17] = mk(0, 32'h0,        32'h44,       32'h44,       1, 0, 0, 0, 2'b00, 2'b00);
        vecs[18] = mk(1, 32'hFFFFFFFC, 32'h48,       32'h48,       1, 1, 0, 1, 2'b00, 2'b00);
        vecs[19] = mk(0, 32'h0,        32'hFFFFFFFC, 32'h0,        0, 0, 0, 0, 2'b00, 2'b00);
        vecs[20] = mk(0, 32'h0,        32'h0,        32'h0,        1, 0, 0, 0, 2'b00, 2'b00);
        vecs[21] = mk(0, 32'h0,        32'h4,        32'h4,        1, 1, 0, 0, 2'b00, 2'b00);

        pc_b_exp = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8,
                     32'hC, 32'h10, 32'h14, 32'h14, 32'h18};
        stall_b_exp = 11'b001_0001_1100;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset pc",         -1, bus_a.pc,                 32'h100);
        checkOutput("reset ifid_instr", -1, bus_a.ifid_instr,         32'h0);
        checkOutput("reset ifid_pc4",   -1, bus_a.ifid_pc4,           32'h0);
        checkOutput("reset ifid_valid", -1, 32'(bus_a.ifid_valid),    32'h0);
        checkOutput("reset idex_valid", -1, 32'(bus_a.idex_valid),    32'h0);
        checkOutput("reset stall",      -1, 32'(bus_a.stall),         32'h0);
        checkOutput("reset flush",      -1, 32'(bus_a.flush),         32'h0);
        checkOutput("reset fwd",        -1, 32'({bus_a.fwd_a, bus_a.fwd_b}), 32'h0);
        checkOutput("reset pc_b",       -1, bus_b.pc,                 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 22; r++) begin
            applyStimulus(vecs[r]);
            #1;
            checkRow(r, vecs[r]);
            @(negedge clk);
        end

        // Reset pulled in the middle of the low phase must clear state with no clock edge.
        bus_a.ex_branch_taken = 1'b0;
        bus_a.ex_target       = '0;
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset pc",         -2, bus_a.pc,              32'h100);
        checkOutput("async reset ifid_valid", -2, 32'(bus_a.ifid_valid), 32'h0);
        checkOutput("async reset idex_valid", -2, 32'(bus_a.idex_valid), 32'h0);
        checkOutput("async reset ifid_pc4",   -2, bus_a.ifid_pc4,        32'h0);
        checkOutput("async reset pc_b",       -2, bus_b.pc,              32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 11; r++) begin
            #1;
            checkOutput("nofwd pc",    100 + r, bus_b.pc,                 pc_b_exp[r]);
            checkOutput("nofwd stall", 100 + r, 32'(bus_b.stall),         32'(stall_b_exp[r]));
            checkOutput("nofwd fwd_a", 100 + r, 32'(bus_b.fwd_a),         32'h0);
            checkOutput("nofwd fwd_b", 100 + r, 32'(bus_b.fwd_b),         32'h0);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
